// File: rtl/mem_pkg.sv
// Shared definitions for the shared-RAM arbiter slice: arbitration modes and a
// ceil-log2 helper used to size the round-robin pointer.
package mem_pkg;

  typedef enum logic {
    ARB_RR    = 1'b0,
    ARB_FIXED = 1'b1
  } arb_mode_e;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// One-hot grant generator for NUM_CH masters: round-robin or fixed priority,
// with a lock owner that is re-granted for back-to-back accesses.
module rr_arbiter
  import mem_pkg::*;
#(
  parameter int unsigned NUM_CH   = 2,
  parameter int unsigned ARB_MODE = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] req,
  input  logic [NUM_CH-1:0] lock,
  output logic [NUM_CH-1:0] gnt
);

  localparam int unsigned PTR_W = (NUM_CH > 1) ? clog2(NUM_CH) : 1;
  localparam arb_mode_e   MODE  = arb_mode_e'(ARB_MODE[0]);

  generate
    if (NUM_CH == 1) begin : g_single
      assign gnt = req;
    end else begin : g_multi
      logic [PTR_W-1:0]  ptr, ptr_next;
      logic [PTR_W-1:0]  owner, owner_next;
      logic              owner_vld, owner_vld_next;
      logic [PTR_W-1:0]  grant_idx, idx;
      logic              found, locked;
      logic [NUM_CH-1:0] gnt_c;
      int unsigned       cand;

      always_comb begin
        gnt_c          = '0;
        ptr_next       = ptr;
        owner_next     = owner;
        owner_vld_next = 1'b0;
        grant_idx      = '0;
        idx            = '0;
        cand           = 0;
        found          = 1'b0;
        locked         = 1'b0;

        // A held lock overrides both arbitration modes and freezes the pointer.
        if (owner_vld && req[owner]) begin
          grant_idx = owner;
          found     = 1'b1;
          locked    = 1'b1;
        end else if (MODE == ARB_FIXED) begin
          for (int unsigned i = 0; i < NUM_CH; i++) begin
            idx = PTR_W'(i);
            if (!found && req[idx]) begin
              grant_idx = idx;
              found     = 1'b1;
            end
          end
        end else begin
          for (int unsigned i = 0; i < NUM_CH; i++) begin
            cand = 32'(ptr) + i;
            if (cand >= NUM_CH) cand = cand - NUM_CH;
            idx = PTR_W'(cand);
            if (!found && req[idx]) begin
              grant_idx = idx;
              found     = 1'b1;
            end
          end
        end

        if (found) begin
          gnt_c[grant_idx] = 1'b1;
          owner_vld_next   = lock[grant_idx];
          owner_next       = grant_idx;
          if (!locked && MODE == ARB_RR)
            ptr_next = (grant_idx == PTR_W'(NUM_CH - 1)) ? '0 : grant_idx + 1'b1;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ptr       <= '0;
          owner     <= '0;
          owner_vld <= 1'b0;
        end else begin
          ptr       <= ptr_next;
          owner     <= owner_next;
          owner_vld <= owner_vld_next;
        end
      end

      assign gnt = gnt_c;
    end
  endgenerate

endmodule

// File: rtl/shared_ram_arbiter.sv
// Single synchronous RAM shared by NUM_CH masters through rr_arbiter; read data,
// read-valid and range-error are registered one cycle after the grant.
module shared_ram_arbiter
  import mem_pkg::*;
#(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned DEPTH    = 256,
  parameter int unsigned NUM_CH   = 2,
  parameter int unsigned ARB_MODE = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH-1:0]        req,
  input  logic [NUM_CH-1:0]        we,
  input  logic [NUM_CH-1:0]        lock,
  input  logic [NUM_CH*ADDR_W-1:0] addr,
  input  logic [NUM_CH*DATA_W-1:0] din,
  output logic [NUM_CH-1:0]        gnt,
  output logic [NUM_CH-1:0]        rvalid,
  output logic [DATA_W-1:0]        dout,
  output logic                     err
);

  logic [NUM_CH-1:0] arb_gnt;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_din;
  logic              sel_we, sel_vld, in_range;
  logic [DATA_W-1:0] mem [DEPTH];

  rr_arbiter #(
    .NUM_CH  (NUM_CH),
    .ARB_MODE(ARB_MODE)
  ) u_arb (
    .clk  (clk),
    .rst_n(rst_n),
    .req  (req),
    .lock (lock),
    .gnt  (arb_gnt)
  );

  // Grant is masked during reset so no access can commit while rst_n is low.
  assign gnt = rst_n ? arb_gnt : '0;

  always_comb begin
    sel_vld  = 1'b0;
    sel_we   = 1'b0;
    sel_addr = '0;
    sel_din  = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (gnt[i]) begin
        sel_vld  = 1'b1;
        sel_we   = we[i];
        sel_addr = addr[i*ADDR_W +: ADDR_W];
        sel_din  = din[i*DATA_W +: DATA_W];
      end
    end
  end

  assign in_range = (32'(sel_addr) < DEPTH);

  always_ff @(posedge clk) begin
    if (sel_vld && sel_we && in_range)
      mem[sel_addr] <= sel_din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid <= '0;
      dout   <= '0;
      err    <= 1'b0;
    end else begin
      rvalid <= (sel_vld && !sel_we) ? gnt : '0;
      err    <= sel_vld && !in_range;
      if (sel_vld && !sel_we)
        dout <= in_range ? mem[sel_addr] : '0;
    end
  end

endmodule

// File: tb/tb_shared_ram_arbiter.sv
// Scoreboard bench: a round-robin DUT (DEPTH=200) and a fixed-priority DUT share
// the same stimulus; read-path expectations are queued at grant and popped next cycle.
module tb_shared_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req = '0, we = '0, lock = '0;
  logic [15:0] addr = '0, din = '0;
  logic [1:0]  gnt, rvalid, fx_gnt, fx_rvalid;
  logic [7:0]  dout, fx_dout;
  logic        err, fx_err;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [1:0] rv;
    logic [7:0] dout;
    logic       err;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] mdl [0:255];
  logic [7:0] m_dout = '0;

  always #5 clk = ~clk;

  shared_ram_arbiter #(
    .DATA_W(8), .ADDR_W(8), .DEPTH(200), .NUM_CH(2), .ARB_MODE(0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .lock(lock), .addr(addr), .din(din),
    .gnt(gnt), .rvalid(rvalid), .dout(dout), .err(err)
  );

  shared_ram_arbiter #(
    .DATA_W(8), .ADDR_W(8), .DEPTH(256), .NUM_CH(2), .ARB_MODE(1)
  ) dut_fx (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .lock(lock), .addr(addr), .din(din),
    .gnt(fx_gnt), .rvalid(fx_rvalid), .dout(fx_dout), .err(fx_err)
  );

  // Reference model of the DEPTH=200 RAM; records what the next cycle must show.
  task automatic push_exp(input logic [1:0] g);
    exp_t       e;
    int         ch;
    logic [7:0] a;
    ch    = g[1] ? 1 : 0;
    a     = addr[ch*8 +: 8];
    e.rv  = '0;
    e.err = 1'b0;
    if (g != 2'b00) begin
      e.err = (a >= 8'd200);
      if (we[ch]) begin
        if (a < 8'd200) mdl[a] = din[ch*8 +: 8];
      end else begin
        m_dout = (a < 8'd200) ? mdl[a] : 8'h00;
        e.rv   = g;
      end
    end
    e.dout = m_dout;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req  = '0;
    lock = '0;
    @(negedge clk);
    push_exp(2'b00);
    tick();
  endtask

  always @(posedge clk) begin : monitor
    exp_t e;
    #1;
    if (rst_n) begin
      n_checks++;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        if (rvalid !== e.rv || dout !== e.dout || err !== e.err)
          $display("FAIL read_path @%0t: rvalid=%b dout=%h err=%b, expected rvalid=%b dout=%h err=%b",
                   $time, rvalid, dout, err, e.rv, e.dout, e.err);
        else n_pass++;
      end else begin
        if (rvalid !== 2'b00 || err !== 1'b0)
          $display("FAIL idle_outputs @%0t: rvalid=%b err=%b, expected 00/0", $time, rvalid, err);
        else n_pass++;
      end
    end
  end

  task automatic test_reset();
    req = 2'b11;
    #2;
    n_checks++; if (gnt !== 2'b00) $display("FAIL reset_gnt: got %b want 00", gnt); else n_pass++;
    n_checks++; if (rvalid !== 2'b00) $display("FAIL reset_rvalid: got %b want 00", rvalid); else n_pass++;
    n_checks++; if (dout !== 8'h00) $display("FAIL reset_dout: got %h want 00", dout); else n_pass++;
    n_checks++; if (err !== 1'b0) $display("FAIL reset_err: got %b want 0", err); else n_pass++;
    req = '0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_channel();
    req = 2'b01; we = 2'b01; addr[7:0] = 8'h20; din[7:0] = 8'hA5;
    @(negedge clk);
    n_checks++; if (gnt !== 2'b01) $display("FAIL single_write_gnt: got %b want 01", gnt); else n_pass++;
    push_exp(2'b01);
    tick();
    we = 2'b00;
    @(negedge clk);
    n_checks++; if (gnt !== 2'b01) $display("FAIL single_read_gnt: got %b want 01", gnt); else n_pass++;
    push_exp(2'b01);
    tick();
    n_checks++; if (fx_dout !== 8'hA5) $display("FAIL fx_read_dout: got %h want a5", fx_dout); else n_pass++;
    n_checks++; if (fx_rvalid !== 2'b01) $display("FAIL fx_read_rvalid: got %b want 01", fx_rvalid); else n_pass++;
    idle();
  endtask

  task automatic test_reset_midrun();
    req = 2'b01; we = 2'b01; addr[7:0] = 8'h10; din[7:0] = 8'h3C;
    @(negedge clk);
    n_checks++; if (gnt !== 2'b01) $display("FAIL rst_write_gnt: got %b want 01", gnt); else n_pass++;
    push_exp(2'b01);
    tick();
    we = 2'b00;
    @(negedge clk);
    n_checks++; if (gnt !== 2'b01) $display("FAIL rst_read_gnt: got %b want 01", gnt); else n_pass++;
    push_exp(2'b01);
    tick();
    #1 rst_n = 1'b0;
    #1;
    n_checks++; if (rvalid !== 2'b00) $display("FAIL midrst_rvalid: got %b want 00", rvalid); else n_pass++;
    n_checks++; if (dout !== 8'h00) $display("FAIL midrst_dout: got %h want 00", dout); else n_pass++;
    n_checks++; if (err !== 1'b0) $display("FAIL midrst_err: got %b want 0", err); else n_pass++;
    n_checks++; if (gnt !== 2'b00) $display("FAIL midrst_gnt: got %b want 00", gnt); else n_pass++;
    sb.delete();
    m_dout = 8'h00;
    @(negedge clk);
    req = '0;
    rst_n = 1'b1;
    tick();
    req = 2'b10; we = 2'b00; addr[15:8] = 8'h10;
    @(negedge clk);
    n_checks++; if (gnt !== 2'b10) $display("FAIL post_rst_gnt: got %b want 10", gnt); else n_pass++;
    push_exp(2'b10);
    tick();
    idle();
  endtask

  task automatic test_round_robin();
    logic [1:0] e;
    req = 2'b11; we = 2'b11;
    addr = {8'h31, 8'h30}; din = {8'h22, 8'h11};
    for (int i = 0; i < 4; i++) begin
      e = (i % 2 == 0) ? 2'b01 : 2'b10;
      @(negedge clk);
      n_checks++; if (gnt !== e) $display("FAIL rr_gnt[%0d]: got %b want %b", i, gnt, e); else n_pass++;
      push_exp(e);
      tick();
    end
    idle();
  endtask

  task automatic test_fixed_priority();
    logic [1:0] e;
    req = 2'b11; we = 2'b11;
    addr = {8'h33, 8'h32}; din = {8'h55, 8'h44};
    for (int i = 0; i < 3; i++) begin
      e = (i % 2 == 0) ? 2'b01 : 2'b10;
      @(negedge clk);
      n_checks++; if (fx_gnt !== 2'b01) $display("FAIL fixed_gnt[%0d]: got %b want 01", i, fx_gnt); else n_pass++;
      n_checks++; if (gnt !== e) $display("FAIL fixed_rr_gnt[%0d]: got %b want %b", i, gnt, e); else n_pass++;
      push_exp(e);
      tick();
      n_checks++;
      if (fx_rvalid !== 2'b00 || fx_err !== 1'b0)
        $display("FAIL fixed_write_outputs[%0d]: rvalid=%b err=%b want 00/0", i, fx_rvalid, fx_err);
      else n_pass++;
    end
    idle();
  endtask

  task automatic test_lock();
    req = 2'b10; lock = 2'b10; we = 2'b00; addr = {8'h31, 8'h20};
    @(negedge clk);
    n_checks++; if (gnt !== 2'b10) $display("FAIL lock_first_gnt: got %b want 10", gnt); else n_pass++;
    push_exp(2'b10);
    tick();
    req = 2'b11;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_checks++; if (gnt !== 2'b10) $display("FAIL lock_hold_gnt[%0d]: got %b want 10", i, gnt); else n_pass++;
      push_exp(2'b10);
      tick();
    end
    req = 2'b01; lock = 2'b00;
    @(negedge clk);
    n_checks++; if (gnt !== 2'b01) $display("FAIL lock_release_gnt: got %b want 01", gnt); else n_pass++;
    push_exp(2'b01);
    tick();
    idle();
  endtask

  task automatic test_range();
    logic [7:0] a_list [4];
    logic [1:0] w_list [4];
    logic [7:0] d_list [4];
    a_list = '{8'd50, 8'd250, 8'd250, 8'd50};
    w_list = '{2'b01, 2'b01, 2'b00, 2'b00};
    d_list = '{8'h5A, 8'hFF, 8'h00, 8'h00};
    req = 2'b01;
    for (int i = 0; i < 4; i++) begin
      we = w_list[i]; addr[7:0] = a_list[i]; din[7:0] = d_list[i];
      @(negedge clk);
      n_checks++; if (gnt !== 2'b01) $display("FAIL range_gnt[%0d]: got %b want 01", i, gnt); else n_pass++;
      push_exp(2'b01);
      tick();
    end
    idle();
  endtask

  task automatic test_back_to_back();
    req = 2'b10; we = 2'b10; addr = {8'h40, 8'h40}; din = {8'h77, 8'h00};
    @(negedge clk);
    n_checks++; if (gnt !== 2'b10) $display("FAIL b2b_write_gnt: got %b want 10", gnt); else n_pass++;
    push_exp(2'b10);
    tick();
    we = 2'b00;
    @(negedge clk);
    n_checks++; if (gnt !== 2'b10) $display("FAIL b2b_read_gnt: got %b want 10", gnt); else n_pass++;
    push_exp(2'b10);
    tick();
    req = 2'b01;
    @(negedge clk);
    n_checks++; if (gnt !== 2'b01) $display("FAIL b2b_ch0_read_gnt: got %b want 01", gnt); else n_pass++;
    push_exp(2'b01);
    tick();
    idle();
  endtask

  initial begin
    test_reset();
    test_single_channel();
    test_reset_midrun();
    test_round_robin();
    test_fixed_priority();
    test_lock();
    test_range();
    test_back_to_back();
    idle();
    n_checks++;
    if (sb.size() != 0) $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

endmodule
